fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL define parameter RESET_PC, default 32'h0000_3000, meaning the PC value loaded on reset.
REQ-002 SHALL define port Clk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL define port Rst  input  1  meaning reset; reset is synchronous and active-high.
REQ-004 SHALL define port Stall  input  1  meaning downstream not ready; hold the issued instruction.
REQ-005 SHALL define port Jump  input  1  meaning a jump redirect request, qualified with JumpPC.
REQ-006 SHALL define port Branch  input  1  meaning a taken-branch redirect request, qualified with BranchPC.
REQ-007 SHALL define port JumpPC  input  32  meaning the jump target.
REQ-008 SHALL define port BranchPC  input  32  meaning the branch target.
REQ-009 SHALL define port ImemAck  input  1  meaning the instruction memory returns ImemRdata this cycle.
REQ-010 SHALL define port ImemRdata  input  32  meaning the fetched instruction word.
REQ-011 SHALL define port ImemReq  output  1  meaning a fetch request is outstanding.
REQ-012 SHALL define port ImemAddr  output  32  meaning the fetch address.
REQ-013 SHALL define port PCNow  output  32  meaning the PC of the current fetch or issued instruction.
REQ-014 SHALL define port PCPlus  output  32  meaning PCNow+4.
REQ-015 SHALL define port Instruction  output  32  meaning the issued instruction word.
REQ-016 SHALL define port InstrValid  output  1  meaning Instruction/PCNow form a valid issued pair.

Function
REQ-017 SHALL implement a two-state FSM: FETCH (request outstanding) and ISSUE (instruction presented).
REQ-018 SHALL drive ImemReq=1 and ImemAddr=PCNow in FETCH, and ImemReq=0 in ISSUE.
REQ-019 SHALL force bits [1:0] of every loaded PC, including targets and RESET_PC, to 2'b00.
REQ-020 SHALL compute PCPlus combinationally as PCNow+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-021 SHALL resolve simultaneous Jump and Branch in favour of Jump (JumpPC) in every state.
REQ-022 SHALL, in FETCH with ImemAck=1 and no pending or same-cycle redirect, register ImemRdata into Instruction, set InstrValid=1 and enter ISSUE on the next cycle.
REQ-023 SHALL, in FETCH, record Jump/Branch into a pending-redirect register (valid bit plus target), with a later redirect overwriting an earlier one.
REQ-024 SHALL, in FETCH with ImemAck=1 and a pending or same-cycle redirect, discard ImemRdata, load PCNow with the target, clear the pending entry and remain in FETCH with InstrValid=0.
REQ-025 SHALL apply same-cycle redirect priority over the pending-redirect register when both exist at ImemAck.
REQ-026 SHALL, in ISSUE with Stall=1, hold PCNow, Instruction and InstrValid, and ignore Jump/Branch.
REQ-027 SHALL, in ISSUE with Stall=0, load PCNow with JumpPC, BranchPC or PCNow+4 (REQ-021 priority), clear InstrValid and enter FETCH next cycle.
REQ-028 SHALL keep ImemAddr constant while in FETCH until ImemAck, so each address is requested exactly once per FETCH entry.
REQ-029 SHALL issue exactly one instruction per ISSUE entry; 1-cycle ImemAck gives a 2-cycle minimum issue interval.

Reset
REQ-030 SHALL, on Clk edge with Rst=1, set PCNow=RESET_PC, Instruction=0, InstrValid=0, clear the pending redirect and enter FETCH, overriding all other inputs.
REQ-031 SHALL drop an in-flight fetch when Rst is asserted mid-FETCH; an ImemAck in that reset cycle is ignored.
REQ-032 SHALL drive ImemReq=1, ImemAddr=RESET_PC in the first cycle after reset deasserts.

Verification
REQ-033 SHALL verify reset: Rst 1 cycle, ImemAck=1 with ImemRdata=0x24080001 -> next cycle InstrValid=1, PCNow=0x3000, Instruction=0x24080001.
REQ-034 SHALL verify sequential fetch: 3 fetches, Stall=0 -> ImemAddr 0x3000, 0x3004, 0x3008, one ImemReq per address.
REQ-035 SHALL verify redirect priority: ISSUE at 0x3004 with Jump=1 (JumpPC=0x3100) and Branch=1 (BranchPC=0x3200) -> next ImemAddr=0x3100.
REQ-036 SHALL verify pending redirect: Branch=1 (0x3040) during FETCH at 0x3008 with ack delayed 3 cycles -> data at ack dropped, InstrValid stays 0, next ImemAddr=0x3040.
REQ-037 SHALL verify stall: Stall=1 for 4 cycles in ISSUE with Jump=1 pulsed -> Instruction/PCNow unchanged, jump ignored, then PC+4 fetched after Stall=0.
REQ-038 SHALL verify wrap and alignment: PCNow=0xFFFFFFFC, Stall=0, no redirect -> next ImemAddr=0x00000000; JumpPC=0x3103 -> ImemAddr=0x3100.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer, its instruction memory and the
// downstream consumer of issued instructions.
interface fetch_sequencer_if;
  logic        Stall;
  logic        Jump;
  logic        Branch;
  logic [31:0] JumpPC;
  logic [31:0] BranchPC;
  logic        ImemAck;
  logic [31:0] ImemRdata;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] PCNow;
  logic [31:0] PCPlus;
  logic [31:0] Instruction;
  logic        InstrValid;
  // Debug view of the FSM: 0 = FETCH, 1 = ISSUE.
  logic        DbgState;

  // Handshakes: ImemReq/ImemAddr stay stable until ImemAck (ack is the
  // response strobe, data valid that cycle). InstrValid is the issue valid;
  // Stall is the inverted ready and holds the issued pair while high.
  modport master (
    input  Stall, Jump, Branch, JumpPC, BranchPC, ImemAck, ImemRdata,
    output ImemReq, ImemAddr, PCNow, PCPlus, Instruction, InstrValid, DbgState
  );

  modport slave (
    output Stall, Jump, Branch, JumpPC, BranchPC, ImemAck, ImemRdata,
    input  ImemReq, ImemAddr, PCNow, PCPlus, Instruction, InstrValid, DbgState
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Two-state fetch/issue sequencer: requests one instruction word per PC,
// presents it downstream, and steers the PC on jumps and taken branches.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic              Clk,
  input logic              Rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instr, instr_n;
  logic        instr_valid, instr_valid_n;
  logic        pend_valid, pend_valid_n;
  logic [31:0] pend_pc, pend_pc_n;

  logic        redirect_now;
  logic [31:0] redirect_tgt;

  // Jump wins over Branch; all targets are word aligned on load.
  assign redirect_now = bus.Jump | bus.Branch;
  assign redirect_tgt = (bus.Jump ? bus.JumpPC : bus.BranchPC) & 32'hFFFF_FFFC;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC & 32'hFFFF_FFFC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      pend_valid  <= 1'b0;
      pend_pc     <= 32'h0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_valid <= instr_valid_n;
      pend_valid  <= pend_valid_n;
      pend_pc     <= pend_pc_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_n       = instr;
    instr_valid_n = instr_valid;
    pend_valid_n  = pend_valid;
    pend_pc_n     = pend_pc;

    unique case (state)
      S_FETCH: begin
        if (bus.ImemAck) begin
          // A same-cycle redirect beats the pending one; either way the
          // returned word belongs to the wrong path and is dropped.
          if (redirect_now) begin
            pc_n         = redirect_tgt;
            pend_valid_n = 1'b0;
          end else if (pend_valid) begin
            pc_n         = pend_pc;
            pend_valid_n = 1'b0;
          end else begin
            instr_n       = bus.ImemRdata;
            instr_valid_n = 1'b1;
            state_n       = S_ISSUE;
          end
        end else if (redirect_now) begin
          pend_valid_n = 1'b1;
          pend_pc_n    = redirect_tgt;
        end
      end
      S_ISSUE: begin
        if (!bus.Stall) begin
          pc_n          = redirect_now ? redirect_tgt : pc + 32'd4;
          instr_valid_n = 1'b0;
          state_n       = S_FETCH;
        end
      end
      default: state_n = S_FETCH;
    endcase
  end

  assign bus.ImemReq     = (state == S_FETCH);
  assign bus.ImemAddr    = pc;
  assign bus.PCNow       = pc;
  assign bus.PCPlus      = pc + 32'd4;
  assign bus.Instruction = instr;
  assign bus.InstrValid  = instr_valid;
  assign bus.DbgState    = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table plus hand-built
// sequences for pending redirects, stalls and PC wrap.
module tb_fetch_sequencer;

  logic Clk;
  logic Rst;
  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_3000)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic        jump;
    logic        branch;
    logic [31:0] jpc;
    logic [31:0] bpc;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_issue;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic vec_t mk(string name, logic rst, logic stall, logic jump,
                              logic branch, logic [31:0] jpc, logic [31:0] bpc,
                              logic ack, logic [31:0] rdata, logic exp_issue,
                              logic [31:0] exp_pc, logic [31:0] exp_instr);
    vec_t v;
    v.name = name; v.rst = rst; v.stall = stall; v.jump = jump;
    v.branch = branch; v.jpc = jpc; v.bpc = bpc; v.ack = ack;
    v.rdata = rdata; v.exp_issue = exp_issue; v.exp_pc = exp_pc;
    v.exp_instr = exp_instr;
    return v;
  endfunction

  task automatic check(string nm, string field, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then check the outputs after the edge.
  task automatic apply(vec_t v);
    logic [31:0] exp_plus;
    Rst        = v.rst;
    bus.Stall  = v.stall;
    bus.Jump   = v.jump;
    bus.Branch = v.branch;
    bus.JumpPC = v.jpc;
    bus.BranchPC  = v.bpc;
    bus.ImemAck   = v.ack;
    bus.ImemRdata = v.rdata;
    @(posedge Clk);
    #1;
    exp_plus = v.exp_pc + 32'd4;
    check(v.name, "state",  {31'b0, bus.DbgState},   {31'b0, v.exp_issue});
    check(v.name, "req",    {31'b0, bus.ImemReq},    {31'b0, ~v.exp_issue});
    check(v.name, "valid",  {31'b0, bus.InstrValid}, {31'b0, v.exp_issue});
    check(v.name, "pc",     bus.PCNow,  v.exp_pc);
    check(v.name, "pcplus", bus.PCPlus, exp_plus);
    if (!v.exp_issue) check(v.name, "addr", bus.ImemAddr, v.exp_pc);
    if (v.exp_issue || v.rst) check(v.name, "instr", bus.Instruction, v.exp_instr);
  endtask

  task automatic cyc(string name, logic rst, logic stall, logic jump, logic branch,
                     logic [31:0] jpc, logic [31:0] bpc, logic ack, logic [31:0] rdata,
                     logic exp_issue, logic [31:0] exp_pc, logic [31:0] exp_instr);
    apply(mk(name, rst, stall, jump, branch, jpc, bpc, ack, rdata,
             exp_issue, exp_pc, exp_instr));
  endtask

  initial begin
    Rst = 1'b1;
    bus.Stall = 1'b0; bus.Jump = 1'b0; bus.Branch = 1'b0;
    bus.JumpPC = '0; bus.BranchPC = '0; bus.ImemAck = 1'b0; bus.ImemRdata = '0;
    @(posedge Clk);
    #1;

    //             name        rst stl jmp br  jpc           bpc           ack rdata         iss pc            instr
    tbl.push_back(mk("reset",    1, 0, 0, 0, 32'h0,        32'h0,        1, 32'hDEAD_0000, 0, 32'h0000_3000, 32'h0));
    tbl.push_back(mk("first",    0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h2408_0001, 1, 32'h0000_3000, 32'h2408_0001));
    tbl.push_back(mk("seq1",     0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 32'h0000_3004, 32'h0));
    tbl.push_back(mk("seq1wait", 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 32'h0000_3004, 32'h0));
    tbl.push_back(mk("seq1ack",  0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h1111_1111, 1, 32'h0000_3004, 32'h1111_1111));
    tbl.push_back(mk("seq2",     0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 32'h0000_3008, 32'h0));
    tbl.push_back(mk("seq2ack",  0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h2222_2222, 1, 32'h0000_3008, 32'h2222_2222));
    tbl.push_back(mk("reset2",   1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 32'h0000_3000, 32'h0));
    tbl.push_back(mk("r2ack",    0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h3333_3333, 1, 32'h0000_3000, 32'h3333_3333));
    tbl.push_back(mk("r2next",   0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 32'h0000_3004, 32'h0));
    tbl.push_back(mk("r2ack2",   0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h4444_4444, 1, 32'h0000_3004, 32'h4444_4444));
    tbl.push_back(mk("prio",     0, 0, 1, 1, 32'h0000_3100, 32'h0000_3200, 0, 32'h0,      0, 32'h0000_3100, 32'h0));
    tbl.push_back(mk("prioack",  0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h5555_5555, 1, 32'h0000_3100, 32'h5555_5555));
    tbl.push_back(mk("brnalign", 0, 0, 0, 1, 32'h0,        32'h0000_3203, 0, 32'h0,      0, 32'h0000_3200, 32'h0));
    tbl.push_back(mk("sameack",  0, 0, 1, 0, 32'h0000_3303, 32'h0,       1, 32'hDEAD_BEEF, 0, 32'h0000_3300, 32'h0));
    tbl.push_back(mk("sameok",   0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h6666_6666, 1, 32'h0000_3300, 32'h6666_6666));
    tbl.push_back(mk("jmpalign", 0, 0, 1, 0, 32'h0000_3103, 32'h0,       0, 32'h0,         0, 32'h0000_3100, 32'h0));
    tbl.push_back(mk("rstack",   1, 0, 0, 0, 32'h0,        32'h0,        1, 32'hBAD0_BAD0, 0, 32'h0000_3000, 32'h0));

    foreach (tbl[i]) apply(tbl[i]);

    // Pending branch during a slow fetch, overwrite, and same-cycle priority.
    cyc("pa_i0",   0, 0, 0, 0, 0, 0,             1, 32'h10, 1, 32'h0000_3000, 32'h10);
    cyc("pa_f1",   0, 0, 0, 0, 0, 0,             0, 0,      0, 32'h0000_3004, 0);
    cyc("pa_i1",   0, 0, 0, 0, 0, 0,             1, 32'h20, 1, 32'h0000_3004, 32'h20);
    cyc("pa_f2",   0, 0, 0, 0, 0, 0,             0, 0,      0, 32'h0000_3008, 0);
    cyc("pa_br",   0, 0, 0, 1, 0, 32'h0000_3040, 0, 0,      0, 32'h0000_3008, 0);
    cyc("pa_w1",   0, 0, 0, 0, 0, 0,             0, 0,      0, 32'h0000_3008, 0);
    cyc("pa_w2",   0, 0, 0, 0, 0, 0,             0, 0,      0, 32'h0000_3008, 0);
    cyc("pa_drop", 0, 0, 0, 0, 0, 0,             1, 32'hBAD1, 0, 32'h0000_3040, 0);
    cyc("pa_tgt",  0, 0, 0, 0, 0, 0,             1, 32'h30, 1, 32'h0000_3040, 32'h30);
    cyc("ow_f",    0, 0, 0, 0, 0, 0,             0, 0,      0, 32'h0000_3044, 0);
    cyc("ow_j",    0, 0, 1, 0, 32'h0000_3500, 0, 0, 0,      0, 32'h0000_3044, 0);
    cyc("ow_b",    0, 0, 0, 1, 0, 32'h0000_3600, 0, 0,      0, 32'h0000_3044, 0);
    cyc("ow_ack",  0, 0, 0, 0, 0, 0,             1, 32'hBAD2, 0, 32'h0000_3600, 0);
    cyc("sp_b",    0, 0, 0, 1, 0, 32'h0000_3700, 0, 0,      0, 32'h0000_3600, 0);
    cyc("sp_ackj", 0, 0, 1, 0, 32'h0000_3800, 0, 1, 32'hBAD3, 0, 32'h0000_3800, 0);
    cyc("sp_tgt",  0, 0, 0, 0, 0, 0,             1, 32'h40, 1, 32'h0000_3800, 32'h40);

    // Stall holds the issued pair and ignores a jump pulse.
    cyc("st1",     0, 1, 0, 0, 0, 0,             0, 0,      1, 32'h0000_3800, 32'h40);
    cyc("st2",     0, 1, 1, 0, 32'h0000_3900, 0, 0, 0,      1, 32'h0000_3800, 32'h40);
    cyc("st3",     0, 1, 0, 0, 0, 0,             1, 32'hBAD4, 1, 32'h0000_3800, 32'h40);
    cyc("st4",     0, 1, 0, 0, 0, 0,             0, 0,      1, 32'h0000_3800, 32'h40);
    cyc("st_rel",  0, 0, 0, 0, 0, 0,             0, 0,      0, 32'h0000_3804, 0);

    // Jump to the top word, then sequential wrap to zero.
    cyc("wr_i",    0, 0, 0, 0, 0, 0,             1, 32'h50, 1, 32'h0000_3804, 32'h50);
    cyc("wr_j",    0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0,      0, 32'hFFFF_FFFC, 0);
    cyc("wr_top",  0, 0, 0, 0, 0, 0,             1, 32'h60, 1, 32'hFFFF_FFFC, 32'h60);
    cyc("wr_zero", 0, 0, 0, 0, 0, 0,             0, 0,      0, 32'h0000_0000, 0);
    cyc("wr_i0",   0, 0, 0, 0, 0, 0,             1, 32'h70, 1, 32'h0000_0000, 32'h70);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
